// File: rtl/i3c_pkg.sv
// ----------------------------------------------------------------------------
// i3c_pkg: shared states and line levels for the I3C_BUS initiator.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package i3c_pkg;
  localparam int   DEF_DATA_W  = 16;
  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_CLK    = 1'b1;
  localparam logic IDLE_DAT    = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_LO = 3'd1,
    START_HI = 3'd2,
    BIT_LO   = 3'd3,
    BIT_HI   = 3'd4,
    GAP      = 3'd5,
    PAR_LO   = 3'd6,
    PAR_HI   = 3'd7
  } state_t;
endpackage

`default_nettype wire

// File: rtl/i3c_half_tick.sv
// ----------------------------------------------------------------------------
// i3c_half_tick: bus half-period timer, tick on the last clk of each half.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i3c_half_tick
  import i3c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (restart || cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

`default_nettype wire

// File: rtl/i3c_bus_master.sv
// ----------------------------------------------------------------------------
// i3c_bus_master: I3C_BUS initiator, full-duplex framed word exchange.
// Option macro: I3C_BUS_MASTER_PARITY_EN (odd parity bit + rx_perr).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i3c_bus_master
  import i3c_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CLK_DIV   = 4,
  parameter int GAP_HALFS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              bus_clk_o,
  output logic              bus_dout,
  input  logic              bus_din
`ifdef I3C_BUS_MASTER_PARITY_EN
  ,
  output logic              rx_perr
`endif
);

  // The idle cycle in which tx_ready is high counts as the last gap cycle,
  // so back-to-back frames are spaced by exactly GAP_HALFS half-periods.
  localparam int GAP_CYC = GAP_HALFS * CLK_DIV - 1;
  localparam int CNT_W   = $clog2(DATA_W + GAP_CYC + 1);

  state_t             state, state_n;
  logic               tick;
  logic               restart;
  logic               accept;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  tx_shift;
  logic [DATA_W-1:0]  rx_shift;
  logic               din_s1, din_s2;
`ifdef I3C_BUS_MASTER_PARITY_EN
  logic               par_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid & tx_ready;
  assign restart  = (state == IDLE);
  assign last     = (cnt == '0);

  i3c_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (tx_valid) state_n = START_LO;
      START_LO: if (tick) state_n = START_HI;
      START_HI: if (tick) state_n = BIT_LO;
      BIT_LO:   if (tick) state_n = BIT_HI;
      BIT_HI: begin
        if (tick) begin
          if (!last) begin
            state_n = BIT_LO;
          end else begin
`ifdef I3C_BUS_MASTER_PARITY_EN
            state_n = PAR_LO;
`else
            state_n = GAP;
`endif
          end
        end
      end
`ifdef I3C_BUS_MASTER_PARITY_EN
      PAR_LO:   if (tick) state_n = PAR_HI;
      PAR_HI:   if (tick) state_n = GAP;
`endif
      GAP:      if (last) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_clk_o <= IDLE_CLK;
      bus_dout  <= IDLE_DAT;
      cnt       <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      din_s1    <= 1'b0;
      din_s2    <= 1'b0;
`ifdef I3C_BUS_MASTER_PARITY_EN
      par_bit   <= 1'b0;
      rx_perr   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bus_clk_o <= (state_n inside {START_LO, BIT_LO, PAR_LO}) ? ~IDLE_CLK : IDLE_CLK;
      din_s1    <= bus_din;
      din_s2    <= din_s1;
      rx_valid  <= 1'b0;

      if (accept) begin
        tx_shift <= tx_data;
`ifdef I3C_BUS_MASTER_PARITY_EN
        par_bit  <= ~^tx_data;
`endif
      end

      // Data line only moves on entry to a LOW half (or to the gap).
      if (state_n != state) begin
        case (state_n)
          START_LO: bus_dout <= START_LEVEL;
          BIT_LO: begin
            bus_dout <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            cnt      <= (state == START_HI) ? CNT_W'(DATA_W - 1) : cnt - 1'b1;
          end
`ifdef I3C_BUS_MASTER_PARITY_EN
          PAR_LO:   bus_dout <= par_bit;
`endif
          GAP: begin
            bus_dout <= IDLE_DAT;
            cnt      <= CNT_W'(GAP_CYC - 1);
          end
          default: ;
        endcase
      end else if (state == GAP) begin
        cnt <= cnt - 1'b1;
      end

      if (tick && state == BIT_HI) begin
        rx_shift <= {rx_shift[DATA_W-2:0], din_s2};
`ifndef I3C_BUS_MASTER_PARITY_EN
        if (last) begin
          rx_valid <= 1'b1;
          rx_data  <= {rx_shift[DATA_W-2:0], din_s2};
        end
`endif
      end

`ifdef I3C_BUS_MASTER_PARITY_EN
      if (tick && state == PAR_HI) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
        rx_perr  <= ~^{rx_shift, din_s2};
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i3c_bus_master.sv
// ----------------------------------------------------------------------------
// tb_i3c_bus_master: directed bench with a bit-level responder model.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i3c_bus_master;

`ifdef I3C_BUS_MASTER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_BITS = 17 + PB;
  localparam int LAST = 2 * FRAME_BITS * 4;
  localparam int RXN  = LAST + 1;
  localparam int RDY  = LAST + 8;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_HOLD   = 1;
  localparam int MODE_CONT   = 2;
  localparam int MODE_NOISE  = 3;
  localparam int MODE_ABORT  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        bus_clk_o;
  logic        bus_dout;
  logic        bus_din = 1'b0;
`ifdef I3C_BUS_MASTER_PARITY_EN
  logic        rx_perr;
  logic        exp_perr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  i3c_bus_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .bus_clk_o (bus_clk_o),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din)
`ifdef I3C_BUS_MASTER_PARITY_EN
    ,
    .rx_perr   (rx_perr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: drives reply bits on falling bus_clk, records bus_dout on rising bus_clk.
  logic [15:0] rep_word = 16'h0;
  logic        rep_par = 1'b0;
  logic        restart_req = 1'b0;
  logic        prev_restart = 1'b0;
  logic        prev_clk = 1'b1;
  int          fall_idx = 0;
  int          rise_n = 0;
  logic [31:0] cap = 32'h0;

  always @(bus_clk_o or restart_req) begin
    if (restart_req != prev_restart) begin
      fall_idx     = 0;
      rise_n       = 0;
      cap          = 32'h0;
      prev_restart = restart_req;
    end
    if (bus_clk_o !== prev_clk) begin
      if (bus_clk_o === 1'b0) begin
        if (fall_idx >= 1 && fall_idx <= 16) bus_din = rep_word[16 - fall_idx];
        else if (fall_idx == 17)             bus_din = rep_par;
        else                                 bus_din = 1'b0;
        fall_idx++;
      end else if (bus_clk_o === 1'b1) begin
        cap = {cap[30:0], bus_dout};
        rise_n++;
      end
      prev_clk = bus_clk_o;
    end
  end

  task automatic run_frame(input logic [15:0] tx, input logic [15:0] rep, input logic rpar,
                           input int mode, input logic [15:0] nxt, input logic [15:0] nxt_rep);
    int          pulses;
    int          gap_hi;
    int          w;
    logic [31:0] exp_cap;
    pulses = 0;
    gap_hi = 0;
`ifdef I3C_BUS_MASTER_PARITY_EN
    exp_cap = {14'b0, 1'b1, tx, ~^tx};
`else
    exp_cap = {15'b0, 1'b1, tx};
`endif
    if (mode != MODE_CONT) begin
      w = 0;
      while (!tx_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      check("ready_wait", {31'b0, tx_ready}, 32'd1);
      restart_req = ~restart_req;
      rep_word    = rep;
      rep_par     = rpar;
      tx_data     = tx;
      tx_valid    = 1'b1;
    end
    for (int n = 1; n <= RDY; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("clk_low_after_accept", {31'b0, bus_clk_o}, 32'd0);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        if (mode == MODE_HOLD) tx_data = nxt;
        else                   tx_valid = 1'b0;
      end
      if (mode == MODE_NOISE) begin
        if (n == 10) begin
          check("ready_low_busy", {31'b0, tx_ready}, 32'd0);
          tx_valid = 1'b1;
          tx_data  = ~tx;
        end
        if (n == 11) tx_valid = 1'b0;
        if (n == 12) begin
          tx_valid = 1'b1;
          tx_data  = 16'h0000;
        end
        if (n == 13) tx_valid = 1'b0;
      end
      if (mode == MODE_ABORT && n == 68) begin
        rst_n = 1'b0;
        #1;
        check("abort_clk", {31'b0, bus_clk_o}, 32'd1);
        check("abort_dout", {31'b0, bus_dout}, 32'd0);
        check("abort_ready", {31'b0, tx_ready}, 32'd1);
        check("abort_rxdata", {16'b0, rx_data}, 32'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("abort_no_rxvalid", {31'b0, rx_valid}, 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      if (rx_valid) pulses++;
      if (n == RXN) begin
        check("rx_valid_timing", {31'b0, rx_valid}, 32'd1);
        check("rx_data", {16'b0, rx_data}, {16'b0, rep});
`ifdef I3C_BUS_MASTER_PARITY_EN
        check("rx_perr", {31'b0, rx_perr}, {31'b0, exp_perr});
`endif
      end
      if (n > LAST && bus_clk_o) gap_hi++;
      if (n == RDY - 1) check("ready_early", {31'b0, tx_ready}, 32'd0);
    end
    check("ready_return", {31'b0, tx_ready}, 32'd1);
    check("frame_bits", rise_n, FRAME_BITS);
    check("dout_seq", cap, exp_cap);
    check("gap_high", gap_hi, 8);
    check("rx_pulses", pulses, 1);
    if (mode == MODE_HOLD) begin
      restart_req = ~restart_req;
      rep_word    = nxt_rep;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk", {31'b0, bus_clk_o}, 32'd1);
    check("rst_dout", {31'b0, bus_dout}, 32'd0);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rxvalid", {31'b0, rx_valid}, 32'd0);
    check("rst_rxdata", {16'b0, rx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(16'hEAAF, 16'hF0FF, 1'b0, MODE_NORMAL, 16'h0, 16'h0);
    run_frame(16'h0001, 16'h3C5A, 1'b0, MODE_HOLD,   16'h8000, 16'h0F0F);
    run_frame(16'h8000, 16'h0F0F, 1'b0, MODE_CONT,   16'h0, 16'h0);
    run_frame(16'h5AA5, 16'h1357, 1'b0, MODE_NOISE,  16'h0, 16'h0);
    run_frame(16'hFFFF, 16'hFFFF, 1'b0, MODE_ABORT,  16'h0, 16'h0);
    run_frame(16'h1234, 16'hA5C3, 1'b0, MODE_NORMAL, 16'h0, 16'h0);
`ifdef I3C_BUS_MASTER_PARITY_EN
    // 16'h0007 has three ones: parity bit 0 gives an odd total (good), 1 gives even (error).
    exp_perr = 1'b0;
    run_frame(16'h0003, 16'h0007, 1'b0, MODE_NORMAL, 16'h0, 16'h0);
    exp_perr = 1'b1;
    run_frame(16'h0003, 16'h0007, 1'b1, MODE_NORMAL, 16'h0, 16'h0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
